aes_sbox_scheduler: RTL and testbench
=====================================

# aes_sbox_scheduler

Time-shares a single 32-bit SubWord unit (four AES S-boxes) between the cipher round datapath (128-bit SubBytes) and the key-expansion datapath (32-bit SubWord). It replaces per-requester S-box banks: the state is processed one column per cycle over four beats, and a key word in one beat. It sits between the round controller, the key scheduler and the shared S-box hardware.

## Interface
- ARB_MODE, 0: tie-break policy. 0 = fixed priority, key first. 1 = round-robin.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_req  in  1  state SubBytes request; held until st_ack.
- st_in  in  128  state to substitute; sampled at acceptance.
- st_ack  out  1  one-cycle pulse: state request accepted.
- st_done  out  1  one-cycle pulse: st_out complete.
- st_out  out  128  substituted state.
- ky_req  in  1  key SubWord request; held until ky_ack.
- ky_in  in  32  word to substitute; sampled at acceptance.
- ky_ack  out  1  one-cycle pulse: key request accepted.
- ky_done  out  1  one-cycle pulse: ky_out valid.
- ky_out  out  32  substituted word.
- busy  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states:
  - IDLE
  - S_ST: four beats, 2-bit counter cnt 0..3.
  - S_KY: one beat.
- IDLE, rising edge:
  - Only st_req high: capture st_in into st_buf, cnt←0, go S_ST, assert st_ack.
  - Only ky_req high: capture ky_in, go S_KY, assert ky_ack.
  - Both high with ARB_MODE=0: key wins.
  - Both high with ARB_MODE=1: the requester not granted last wins. The last-grant register resets to "state", so the first tie goes to key.
  - The losing request stays pending; it is not acked and is re-arbitrated on return to IDLE.
- S_ST beat cnt:
  - SubWord input = st_buf[127-32·cnt -: 32].
  - Result written to st_out at the same word position.
  - Beat 0 = bits [127:96], i.e. bytes 0..3 in FIPS-197 column order.
  - At the edge ending cnt=3: go IDLE and pulse st_done.
- S_KY: SubWord input = captured key word; the result is written to ky_out; go IDLE and pulse ky_done.
- Output holding:
  - st_out holds its last complete value until the first beat of the next state operation overwrites word 0. Words are updated progressively, so st_out is valid only from st_done until the next st_ack.
  - ky_out holds until the next key completion.
- Input capture: st_in and ky_in changes after acceptance are ignored.
- Requester rule: deassert req in the cycle ack is seen. A req still high when the FSM is next in IDLE counts as a new request.
- Reset: asynchronous assertion at any time, including mid-operation, aborts the operation.
  - State → IDLE, cnt→0, last-grant→state.
  - All outputs → 0 (st_out, ky_out, all acks/dones, busy).
  - No done pulse is issued for an aborted operation.

## Timing
- Edge numbering: E0 = the edge that samples the request in IDLE.
- State request:
  - st_ack high in the cycle after E0.
  - Beats complete at E1..E4.
  - st_done high in the cycle after E4.
  - Earliest next acceptance: E5. Occupancy is 4 cycles in S_ST.
- Key request:
  - ky_ack high after E0.
  - ky_out written at E1; ky_done high in the cycle after E1.
  - Next acceptance: E2.
- Combinational path: the S-box lookup is combinational within one cycle, from the buffer mux to the output register. There is no pipelining.
- Throughput:
  - Back-to-back key ops: one per 2 cycles.
  - Back-to-back state ops: one per 5 cycles.
- Ack and done are never high in the same cycle for the same requester. st_done and ky_ack may coincide only across different requesters, which cannot happen because the FSM passes through IDLE between operations.

## Structure
- Shared package aes_pkg holds:
  - FSM state encodings (IDLE, S_ST, S_KY).
  - ST_BEATS = 4.
  - The S-box constant table, also used by SubBytes and key expansion.
- Sub-module aes_sub_word: a combinational 32→32 lookup built from four S-box byte lookups, instantiated once.

## Test plan
- State op, vector 1: st_in=193DE3BEA0F4E22B9AC68D2AE9F84808.
  - Required: st_out=D42711AEE0BF98F1B8B45DE51E415230.
  - st_ack after E0; st_done only in the cycle after E4.
- Key op, FIPS-197 A.1: ky_in=CF4F3C09.
  - Required: ky_out=8A84EB01; ky_done after E1.
- Simultaneous requests:
  - ARB_MODE=0, both asserted repeatedly: key is served before state every time.
  - ARB_MODE=1, same stimulus: grants alternate key, state, key.
- Pending request: assert ky_req at the E2 beat of a state op.
  - Required: ky_ack only after st_done, at the E5 acceptance.
  - st_out is still correct.
- Reset at cnt=2 of a state op.
  - Required: all outputs 0 immediately; no st_done; busy=0.
  - The next request completes correctly.
- Edge values:
  - ky_in=00000000 → 63636363.
  - ky_in=FFFFFFFF → 16161616.
  - Changing st_in after ack does not alter the result.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: scheduler FSM encoding, beat count and the S-box table.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S_ST = 2'd1,
        S_KY = 2'd2
    } sched_state_t;

    localparam int          ST_BEATS  = 4;
    localparam logic [1:0]  LAST_BEAT = 2'(ST_BEATS - 1);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: four parallel S-box byte lookups, no state.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < 4; i++) begin
            dout[8*i +: 8] = sbox_lookup(din[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_sbox_scheduler.sv
// Shares one SubWord unit between 4-beat state SubBytes and 1-beat key SubWord requests.
// Arbitration in IDLE only; a losing request waits un-acked until the FSM returns to IDLE.
module aes_sbox_scheduler
    import aes_pkg::*;
#(
    parameter bit ARB_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req,
    input  logic [127:0] st_in,
    output logic         st_ack,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         ky_req,
    input  logic [31:0]  ky_in,
    output logic         ky_ack,
    output logic         ky_done,
    output logic [31:0]  ky_out,
    output logic         busy
);

    sched_state_t  state;
    logic [1:0]    cnt;
    logic [127:0]  st_buf;
    logic [31:0]   ky_buf;
    logic          last_st;
    logic [31:0]   sw_in;
    logic [31:0]   sw_out;
    logic          grant_ky;

    // Beat 0 takes the most significant word (FIPS-197 column 0).
    always_comb begin
        sw_in = st_buf[127:96];
        if (state == S_KY) begin
            sw_in = ky_buf;
        end else begin
            case (cnt)
                2'd0:    sw_in = st_buf[127:96];
                2'd1:    sw_in = st_buf[95:64];
                2'd2:    sw_in = st_buf[63:32];
                default: sw_in = st_buf[31:0];
            endcase
        end
    end

    aes_sub_word u_sub_word (
        .din  (sw_in),
        .dout (sw_out)
    );

    // Round-robin tie goes to key whenever state was granted last.
    always_comb begin
        grant_ky = ky_req && (!st_req || (ARB_MODE == 1'b0) || last_st);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            st_buf  <= '0;
            ky_buf  <= '0;
            last_st <= 1'b1;
            st_ack  <= 1'b0;
            st_done <= 1'b0;
            st_out  <= '0;
            ky_ack  <= 1'b0;
            ky_done <= 1'b0;
            ky_out  <= '0;
        end else begin
            st_ack  <= 1'b0;
            st_done <= 1'b0;
            ky_ack  <= 1'b0;
            ky_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ky) begin
                        ky_buf  <= ky_in;
                        ky_ack  <= 1'b1;
                        last_st <= 1'b0;
                        state   <= S_KY;
                    end else if (st_req) begin
                        st_buf  <= st_in;
                        cnt     <= 2'd0;
                        st_ack  <= 1'b1;
                        last_st <= 1'b1;
                        state   <= S_ST;
                    end
                end
                S_ST: begin
                    case (cnt)
                        2'd0:    st_out[127:96] <= sw_out;
                        2'd1:    st_out[95:64]  <= sw_out;
                        2'd2:    st_out[63:32]  <= sw_out;
                        default: st_out[31:0]   <= sw_out;
                    endcase
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST_BEAT) begin
                        st_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                S_KY: begin
                    ky_out  <= sw_out;
                    ky_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// Bench: two schedulers (fixed priority and round-robin) driven in parallel, checked every cycle against a GF(2^8)-derived reference.
module tb_aes_sbox_scheduler;

    logic         clk;
    logic         rst = 1'b1;
    logic         st_req  [2];
    logic [127:0] st_in   [2];
    logic         st_ack  [2];
    logic         st_done [2];
    logic [127:0] st_out  [2];
    logic         ky_req  [2];
    logic [31:0]  ky_in   [2];
    logic         ky_ack  [2];
    logic         ky_done [2];
    logic [31:0]  ky_out  [2];
    logic         busy    [2];

    aes_sbox_scheduler #(.ARB_MODE(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .st_req(st_req[0]), .st_in(st_in[0]), .st_ack(st_ack[0]), .st_done(st_done[0]), .st_out(st_out[0]),
        .ky_req(ky_req[0]), .ky_in(ky_in[0]), .ky_ack(ky_ack[0]), .ky_done(ky_done[0]), .ky_out(ky_out[0]),
        .busy(busy[0])
    );

    aes_sbox_scheduler #(.ARB_MODE(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .st_req(st_req[1]), .st_in(st_in[1]), .st_ack(st_ack[1]), .st_done(st_done[1]), .st_out(st_out[1]),
        .ky_req(ky_req[1]), .ky_in(ky_in[1]), .ky_ack(ky_ack[1]), .ky_done(ky_done[1]), .ky_out(ky_out[1]),
        .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference S-box from the field inverse plus affine map.
    logic [7:0] sbox_ref [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_ref[w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes_ref(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref[s[8*i +: 8]];
        return r;
    endfunction

    // Transaction-level model: occupancy countdown per DUT, result released on completion.
    int           rem     [2] = '{0, 0};
    bit           cur_st  [2];
    bit           last_st [2] = '{1'b1, 1'b1};
    bit           take_ky;
    logic [127:0] pend_st [2];
    logic [31:0]  pend_ky [2];
    bit           e_st_ack [2], e_st_done [2], e_ky_ack [2], e_ky_done [2], e_busy [2];
    logic [127:0] e_st_out [2] = '{128'h0, 128'h0};
    logic [31:0]  e_ky_out [2] = '{32'h0, 32'h0};

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            e_st_ack[d]  = 1'b0;
            e_st_done[d] = 1'b0;
            e_ky_ack[d]  = 1'b0;
            e_ky_done[d] = 1'b0;
            if (rst) begin
                rem[d]      = 0;
                last_st[d]  = 1'b1;
                e_st_out[d] = '0;
                e_ky_out[d] = '0;
            end else if (rem[d] > 0) begin
                rem[d]--;
                if (rem[d] == 0) begin
                    if (cur_st[d]) begin
                        e_st_done[d] = 1'b1;
                        e_st_out[d]  = pend_st[d];
                    end else begin
                        e_ky_done[d] = 1'b1;
                        e_ky_out[d]  = pend_ky[d];
                    end
                end
            end else begin
                take_ky = ky_req[d] && (!st_req[d] || d == 0 || last_st[d]);
                if (take_ky) begin
                    rem[d] = 1; cur_st[d] = 1'b0; last_st[d] = 1'b0;
                    pend_ky[d] = sub_word_ref(ky_in[d]);
                    e_ky_ack[d] = 1'b1;
                end else if (st_req[d]) begin
                    rem[d] = 4; cur_st[d] = 1'b1; last_st[d] = 1'b1;
                    pend_st[d] = sub_bytes_ref(st_in[d]);
                    e_st_ack[d] = 1'b1;
                end
            end
            e_busy[d] = (rem[d] > 0);
        end
    end

    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d st_ack", d),  st_ack[d],  e_st_ack[d]);
            chk($sformatf("d%0d st_done", d), st_done[d], e_st_done[d]);
            chk($sformatf("d%0d ky_ack", d),  ky_ack[d],  e_ky_ack[d]);
            chk($sformatf("d%0d ky_done", d), ky_done[d], e_ky_done[d]);
            chk($sformatf("d%0d busy", d),    busy[d],    e_busy[d]);
            chk($sformatf("d%0d ky_out", d),  ky_out[d],  e_ky_out[d]);
            if (!e_busy[d]) chk($sformatf("d%0d st_out", d), st_out[d], e_st_out[d]);
        end
    end

    // Requester behaviour: drop req on ack, optionally re-assert (hold) or randomly request.
    bit hold_st [2] = '{1'b0, 1'b0};
    bit hold_ky [2] = '{1'b0, 1'b0};
    bit rand_on = 1'b0;
    int gseq [2][16];
    int gcnt [2] = '{0, 0};
    int ta_st [2], td_st [2], ta_ky [2], td_ky [2];

    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (st_ack[d] && gcnt[d] < 16) begin gseq[d][gcnt[d]] = 1; gcnt[d]++; end
            if (ky_ack[d] && gcnt[d] < 16) begin gseq[d][gcnt[d]] = 0; gcnt[d]++; end
            if (!st_req[d]) st_in[d] = {$urandom, $urandom, $urandom, $urandom};
            if (!ky_req[d]) ky_in[d] = $urandom;
            if (st_req[d] && st_ack[d]) st_req[d] = 1'b0;
            else if (!st_req[d] && (hold_st[d] || (rand_on && $urandom_range(3) == 0))) st_req[d] = 1'b1;
            if (ky_req[d] && ky_ack[d]) ky_req[d] = 1'b0;
            else if (!ky_req[d] && (hold_ky[d] || (rand_on && $urandom_range(3) == 0))) ky_req[d] = 1'b1;
        end
    endtask

    task automatic measure(input int n, input int inj_t, input logic [31:0] inj_w);
        for (int d = 0; d < 2; d++) begin ta_st[d] = 0; td_st[d] = 0; ta_ky[d] = 0; td_ky[d] = 0; end
        for (int t = 1; t <= n; t++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                if (st_ack[d]  && ta_st[d] == 0) ta_st[d] = t;
                if (st_done[d] && td_st[d] == 0) td_st[d] = t;
                if (ky_ack[d]  && ta_ky[d] == 0) ta_ky[d] = t;
                if (ky_done[d] && td_ky[d] == 0) td_ky[d] = t;
                if (t == inj_t) begin ky_in[d] = inj_w; ky_req[d] = 1'b1; end
            end
        end
    endtask

    task automatic start_st(input logic [127:0] v);
        for (int d = 0; d < 2; d++) begin st_in[d] = v; st_req[d] = 1'b1; end
    endtask

    task automatic key_op(input logic [31:0] w, input logic [31:0] exp);
        for (int d = 0; d < 2; d++) begin ky_in[d] = w; ky_req[d] = 1'b1; end
        measure(4, 0, 32'h0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d key ack time", d), ta_ky[d], 1);
            chk($sformatf("d%0d key done time", d), td_ky[d], 2);
            chk($sformatf("d%0d key %h", d, w), ky_out[d], exp);
        end
    endtask

    localparam logic [127:0] V1_IN  = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
    localparam logic [127:0] V1_OUT = 128'hD42711AEE0BF98F1B8B45DE51E415230;

    initial begin
        for (int d = 0; d < 2; d++) begin
            st_req[d] = 1'b0; ky_req[d] = 1'b0; st_in[d] = '0; ky_in[d] = '0;
        end
        build_sbox();
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset st_out", d), st_out[d], 128'h0);
            chk($sformatf("d%0d reset busy", d), busy[d], 1'b0);
        end
        rst = 1'b0;
        step();

        start_st(V1_IN);
        measure(8, 0, 32'h0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d v1 ack time", d), ta_st[d], 1);
            chk($sformatf("d%0d v1 done time", d), td_st[d], 5);
            chk($sformatf("d%0d v1 st_out", d), st_out[d], V1_OUT);
        end

        key_op(32'hCF4F3C09, 32'h8A84EB01);
        key_op(32'h00000000, 32'h63636363);
        key_op(32'hFFFFFFFF, 32'h16161616);

        start_st(V1_IN);
        measure(10, 2, 32'hCF4F3C09);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d pend st done time", d), td_st[d], 5);
            chk($sformatf("d%0d pend ky ack time", d), ta_ky[d], 6);
            chk($sformatf("d%0d pend ky done time", d), td_ky[d], 7);
            chk($sformatf("d%0d pend st_out", d), st_out[d], V1_OUT);
            chk($sformatf("d%0d pend ky_out", d), ky_out[d], 32'h8A84EB01);
        end

        start_st({$urandom, $urandom, $urandom, $urandom});
        measure(3, 0, 32'h0);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d abort st_out", d), st_out[d], 128'h0);
            chk($sformatf("d%0d abort ky_out", d), ky_out[d], 32'h0);
            chk($sformatf("d%0d abort busy", d), busy[d], 1'b0);
            chk($sformatf("d%0d abort flags", d), {st_ack[d], st_done[d], ky_ack[d], ky_done[d]}, 4'b0);
        end
        step();
        rst = 1'b0;
        measure(6, 0, 32'h0);
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d abort no done", d), td_st[d], 0);
        start_st(V1_IN);
        measure(8, 0, 32'h0);
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d after abort st_out", d), st_out[d], V1_OUT);

        gcnt = '{0, 0};
        hold_st = '{1'b1, 1'b1};
        hold_ky = '{1'b1, 1'b1};
        for (int t = 0; t < 60 && (gcnt[0] < 4 || gcnt[1] < 4); t++) begin
            step();
            for (int d = 0; d < 2; d++) if (gcnt[d] >= 4) begin hold_st[d] = 1'b0; hold_ky[d] = 1'b0; end
        end
        hold_st = '{1'b0, 1'b0};
        hold_ky = '{1'b0, 1'b0};
        chk("tie grant count d0", 128'(gcnt[0] >= 4), 128'h1);
        chk("tie grant count d1", 128'(gcnt[1] >= 4), 128'h1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tie fixed grant %0d", i), gseq[0][i], 0);
            chk($sformatf("tie rr grant %0d", i), gseq[1][i], i % 2);
        end
        for (int t = 0; t < 40; t++) step();
        chk("tie drained", {st_req[0], ky_req[0], st_req[1], ky_req[1], busy[0], busy[1]}, 6'b0);

        rand_on = 1'b1;
        for (int t = 0; t < 1500; t++) begin
            step();
            if ($urandom_range(199) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
        end
        rand_on = 1'b0;
        for (int t = 0; t < 40; t++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
